// File: rtl/data_arrays_pkg.sv
// Shared definitions for the L1 data-array block: FSM encoding, default
// geometry and the lane-slice helper used to address byte lanes in an entry.
package data_arrays_pkg;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } arr_state_e;

   localparam int DEF_ADDR_W = 10;
   localparam int DEF_LANES  = 16;
   localparam int DEF_LANE_W = 8;

   localparam int DW    = DEF_LANES * DEF_LANE_W;
   localparam int DEPTH = 1 << DEF_ADDR_W;

   // Low bit position of a lane inside an entry.
   function automatic int lane_lo(input int lane, input int lane_w);
      return lane * lane_w;
   endfunction

endpackage

// File: rtl/data_arrays_sram.sv
// Behavioural single-port, lane-masked array. A read lands in the registered
// rdata on the enabled edge; rdata holds whenever en is low or on writes.
module data_arrays_sram
   import data_arrays_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int LANES  = DEF_LANES,
   parameter int LANE_W = DEF_LANE_W
) (
   input  logic                      clock,
   input  logic                      en,
   input  logic                      wmode,
   input  logic [ADDR_W-1:0]         addr,
   input  logic [LANES*LANE_W-1:0]   wdata,
   input  logic [LANES-1:0]          wmask,
   output logic [LANES*LANE_W-1:0]   rdata
);

   localparam int ENTRY_W = LANES * LANE_W;
   localparam int ENTRIES = 1 << ADDR_W;

   logic [ENTRY_W-1:0] mem_r [ENTRIES];
   logic [ENTRY_W-1:0] rdata_r;

   // Single-port access: masked lane write, or registered read; idle otherwise.
   always_ff @(posedge clock) begin
      if (en) begin
         if (wmode) begin
            for (int i = 0; i < LANES; i++) begin
               if (wmask[i]) begin
                  mem_r[addr][lane_lo(i, LANE_W) +: LANE_W] <= wdata[lane_lo(i, LANE_W) +: LANE_W];
               end
            end
         end else begin
            rdata_r <= mem_r[addr];
         end
      end
   end

   assign rdata = rdata_r;

endmodule

// File: rtl/data_arrays_ctrl.sv
// L1 data-array controller: zero-fill sweep after reset, valid/ready request
// channel into a single-port array, and an optionally pipelined read-response
// channel with back-pressure. The array's own read register acts as stage s1.
module data_arrays_ctrl
   import data_arrays_pkg::*;
#(
   parameter int ADDR_W        = 10,
   parameter int LANES         = 16,
   parameter int LANE_W        = 8,
   parameter int READ_PIPE     = 0,
   parameter int INIT_ON_RESET = 1
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [ADDR_W-1:0]         req_addr,
   input  logic                      req_wmode,
   input  logic [LANES*LANE_W-1:0]   req_wdata,
   input  logic [LANES-1:0]          req_wmask,
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic [LANES*LANE_W-1:0]   resp_rdata,
   output logic                      init_done
);

   localparam int ENTRY_W = LANES * LANE_W;

   localparam logic [0:0] S_INIT  = ST_INIT;
   localparam logic [0:0] S_RUN   = ST_RUN;
   localparam logic [0:0] S_RESET = (INIT_ON_RESET != 0) ? S_INIT : S_RUN;

   logic [0:0]          state_r;
   logic [ADDR_W-1:0]   init_cnt_r;
   logic                init_done_r;
   logic                resp_valid_r;

   logic                init_wr_s;
   logic                out_stall_s;
   logic                pipe_stall_s;
   logic                accept_s;
   logic                rd_accept_s;

   logic                sram_en_s;
   logic                sram_wmode_s;
   logic [ADDR_W-1:0]   sram_addr_s;
   logic [ENTRY_W-1:0]  sram_wdata_s;
   logic [LANES-1:0]    sram_wmask_s;
   logic [ENTRY_W-1:0]  sram_rdata_s;

   assign init_wr_s   = (state_r == S_INIT);
   assign out_stall_s = resp_valid_r && !resp_ready;

   // init_done_r gates ready so nothing is accepted while reset is still settling,
   // including the skip-sweep configuration.
   assign req_ready   = init_done_r && (state_r == S_RUN) && !out_stall_s && !pipe_stall_s;
   assign accept_s    = req_valid && req_ready;
   assign rd_accept_s = accept_s && !req_wmode;

   // Sweep writes zero over the full entry; otherwise the request drives the port.
   assign sram_en_s    = init_wr_s || accept_s;
   assign sram_wmode_s = init_wr_s ? 1'b1 : req_wmode;
   assign sram_addr_s  = init_wr_s ? init_cnt_r : req_addr;
   assign sram_wdata_s = init_wr_s ? {ENTRY_W{1'b0}} : req_wdata;
   assign sram_wmask_s = init_wr_s ? {LANES{1'b1}} : req_wmask;

   // Zero-fill sweep over every entry, then RUN until the next reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= S_RESET;
         init_cnt_r  <= {ADDR_W{1'b0}};
         init_done_r <= 1'b0;
      end else begin
         case (state_r)
            S_INIT: begin
               init_cnt_r <= init_cnt_r + ADDR_W'(1);
               if (&init_cnt_r) begin
                  state_r     <= S_RUN;
                  init_done_r <= 1'b1;
               end
            end
            S_RUN: begin
               init_done_r <= 1'b1;
            end
            default: begin
               state_r <= S_RESET;
            end
         endcase
      end
   end

   data_arrays_sram #(
      .ADDR_W (ADDR_W),
      .LANES  (LANES),
      .LANE_W (LANE_W)
   ) u_sram (
      .clock (clock),
      .en    (sram_en_s),
      .wmode (sram_wmode_s),
      .addr  (sram_addr_s),
      .wdata (sram_wdata_s),
      .wmask (sram_wmask_s),
      .rdata (sram_rdata_s)
   );

   generate
      if (READ_PIPE != 0) begin : g_pipe1
         logic               s1_valid_r;
         logic [ENTRY_W-1:0] resp_rdata_r;

         assign pipe_stall_s = s1_valid_r && out_stall_s;

         // s1 is the array read register; hand it to the output register whenever that is free.
         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               s1_valid_r   <= 1'b0;
               resp_valid_r <= 1'b0;
               resp_rdata_r <= {ENTRY_W{1'b0}};
            end else begin
               if (!out_stall_s) begin
                  resp_valid_r <= s1_valid_r;
                  if (s1_valid_r) begin
                     resp_rdata_r <= sram_rdata_s;
                  end
               end
               if (rd_accept_s) begin
                  s1_valid_r <= 1'b1;
               end else if (!out_stall_s) begin
                  s1_valid_r <= 1'b0;
               end
            end
         end

         assign resp_rdata = resp_rdata_r;
      end else begin : g_pipe0
         assign pipe_stall_s = 1'b0;

         // Response valid follows the read handshake; data comes straight from the array register.
         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               resp_valid_r <= 1'b0;
            end else if (rd_accept_s) begin
               resp_valid_r <= 1'b1;
            end else if (resp_ready) begin
               resp_valid_r <= 1'b0;
            end
         end

         // Zero outside a valid response so reset presents all-zero data immediately.
         assign resp_rdata = resp_valid_r ? sram_rdata_s : {ENTRY_W{1'b0}};
      end
   endgenerate

   assign resp_valid = resp_valid_r;
   assign init_done  = init_done_r;

endmodule

// File: tb/tb_data_arrays_ctrl.sv
// Bench for data_arrays_ctrl. Instance 0: defaults (READ_PIPE=0, zero sweep).
// Instance 1: READ_PIPE=1, no sweep. Stimulus pushes expected read data into a
// per-instance queue from a lane-level memory model; monitors pop and compare.
module tb_data_arrays_ctrl;

   localparam int AW  = 10;
   localparam int NL  = 16;
   localparam int LW  = 8;
   localparam int DWT = NL * LW;
   localparam int NE  = 1 << AW;

   logic           clock;
   logic           reset_n;
   logic           req_valid  [2];
   logic           req_ready  [2];
   logic [AW-1:0]  req_addr   [2];
   logic           req_wmode  [2];
   logic [DWT-1:0] req_wdata  [2];
   logic [NL-1:0]  req_wmask  [2];
   logic           resp_valid [2];
   logic           resp_ready [2];
   logic [DWT-1:0] resp_rdata [2];
   logic           init_done  [2];
   logic           rnd_on     [2];

   logic [DWT-1:0] mem_m [2][NE];
   logic [DWT-1:0] exp_q0 [$];
   logic [DWT-1:0] exp_q1 [$];

   int checks   = 0;
   int failures = 0;

   data_arrays_ctrl #(
      .ADDR_W(AW), .LANES(NL), .LANE_W(LW), .READ_PIPE(0), .INIT_ON_RESET(1)
   ) dut0 (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
      .req_wmode(req_wmode[0]), .req_wdata(req_wdata[0]), .req_wmask(req_wmask[0]),
      .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
      .init_done(init_done[0])
   );

   data_arrays_ctrl #(
      .ADDR_W(AW), .LANES(NL), .LANE_W(LW), .READ_PIPE(1), .INIT_ON_RESET(0)
   ) dut1 (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
      .req_wmode(req_wmode[1]), .req_wdata(req_wdata[1]), .req_wmask(req_wmask[1]),
      .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
      .init_done(init_done[1])
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [DWT-1:0] act, input logic [DWT-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int q_size(input int k);
      return (k == 0) ? exp_q0.size() : exp_q1.size();
   endfunction

   function automatic logic [DWT-1:0] q_pop(input int k);
      if (k == 0) return exp_q0.pop_front();
      else return exp_q1.pop_front();
   endfunction

   // Reference: writes update the selected lanes, reads queue the current entry.
   task automatic model_accept(input int k, input logic wm, input logic [AW-1:0] a,
                               input logic [DWT-1:0] d, input logic [NL-1:0] m);
      if (wm) begin
         for (int i = 0; i < NL; i++)
            if (m[i]) mem_m[k][a][i*LW +: LW] = d[i*LW +: LW];
      end else if (k == 0) begin
         exp_q0.push_back(mem_m[k][a]);
      end else begin
         exp_q1.push_back(mem_m[k][a]);
      end
   endtask

   task automatic zero_model0();
      for (int a = 0; a < NE; a++) mem_m[0][a] = '0;
   endtask

   task automatic tick(input int k);
      @(negedge clock);
      if (rnd_on[k]) resp_ready[k] = ($urandom_range(0, 3) != 0);
   endtask

   // Present one request and hold it until accepted (bounded).
   task automatic do_req(input int k, input logic wm, input logic [AW-1:0] a,
                         input logic [DWT-1:0] d, input logic [NL-1:0] m);
      int n;
      req_valid[k] = 1'b1; req_wmode[k] = wm; req_addr[k] = a;
      req_wdata[k] = d;    req_wmask[k] = m;
      #1;
      n = 0;
      while (!req_ready[k] && n < 200) begin
         tick(k); #1; n++;
      end
      chk($sformatf("req_accept%0d", k), DWT'(req_ready[k]), DWT'(1));
      if (req_ready[k]) begin
         model_accept(k, wm, a, d, m);
         tick(k);
      end
      req_valid[k] = 1'b0;
   endtask

   task automatic drain(input int k);
      int n;
      n = 0;
      while (q_size(k) != 0 && n < 100) begin
         tick(k); n++;
      end
      repeat (2) tick(k);
      chk($sformatf("drain%0d", k), DWT'(q_size(k)), DWT'(0));
   endtask

   task automatic wait_init0(output int n, output logic early_ready);
      n = 0; early_ready = 1'b0;
      while (!init_done[0] && n < 2000) begin
         @(negedge clock); n++;
         if (req_ready[0] && !init_done[0]) early_ready = 1'b1;
      end
   endtask

   task automatic rnd_run(input int k, input int nops);
      logic [AW-1:0]  a;
      logic [DWT-1:0] d;
      logic [NL-1:0]  m;
      logic           wm;
      rnd_on[k] = 1'b1;
      for (int i = 0; i < nops; i++) begin
         if ($urandom_range(0, 4) == 0) tick(k);
         a = AW'($urandom_range(0, 31));
         if (k == 0 && $urandom_range(0, 3) == 0) a[AW-1] = 1'b1;
         wm = 1'($urandom_range(0, 1));
         d = {$urandom, $urandom, $urandom, $urandom};
         case ($urandom_range(0, 3))
            0: m = '0;
            1: m = '1;
            default: m = NL'($urandom);
         endcase
         do_req(k, wm, a, d, m);
      end
      rnd_on[k] = 1'b0;
      resp_ready[k] = 1'b1;
      drain(k);
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_mon
      // Scoreboard monitor: response order/data and stability under back-pressure.
      initial begin : mon
         logic           stall_prev;
         logic [DWT-1:0] hold_d;
         logic [DWT-1:0] e;
         stall_prev = 1'b0;
         hold_d = '0;
         forever begin
            @(negedge clock); #2;
            if (stall_prev && reset_n) begin
               chk($sformatf("hold_valid%0d", g), DWT'(resp_valid[g]), DWT'(1));
               chk($sformatf("hold_data%0d", g), resp_rdata[g], hold_d);
            end
            if (reset_n && resp_valid[g] && resp_ready[g]) begin
               chk($sformatf("resp_expected%0d", g), DWT'(q_size(g) != 0), DWT'(1));
               if (q_size(g) != 0) begin
                  e = q_pop(g);
                  chk($sformatf("resp_data%0d", g), resp_rdata[g], e);
               end
            end
            stall_prev = reset_n && resp_valid[g] && !resp_ready[g];
            hold_d = resp_rdata[g];
         end
      end
   end

   initial begin
      #2000000;
      failures++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      logic early;
      reset_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         req_valid[k] = 1'b0; req_addr[k] = '0; req_wmode[k] = 1'b0;
         req_wdata[k] = '0;   req_wmask[k] = '0; resp_ready[k] = 1'b1; rnd_on[k] = 1'b0;
      end
      zero_model0();
      repeat (3) @(negedge clock);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("rst_req_ready%0d", k), DWT'(req_ready[k]), DWT'(0));
         chk($sformatf("rst_resp_valid%0d", k), DWT'(resp_valid[k]), DWT'(0));
         chk($sformatf("rst_resp_rdata%0d", k), resp_rdata[k], '0);
         chk($sformatf("rst_init_done%0d", k), DWT'(init_done[k]), DWT'(0));
      end
      reset_n = 1'b1;

      fork
         begin
            wait_init0(n, early);
            chk("init_cycles0", DWT'(n), DWT'(1024));
            chk("ready_during_init0", DWT'(early), DWT'(0));
            chk("ready_after_init0", DWT'(req_ready[0]), DWT'(1));
         end
         begin
            @(negedge clock); #1;
            chk("noinit_done1", DWT'(init_done[1]), DWT'(1));
            chk("noinit_ready1", DWT'(req_ready[1]), DWT'(1));
            @(negedge clock);
            do_req(1, 1'b1, 10'h3FF, 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978, 16'hFFFF);
            do_req(1, 1'b0, 10'h3FF, '0, '0);
            #1 chk("pipe1_latency_a", DWT'(resp_valid[1]), DWT'(0));
            @(negedge clock); #1;
            chk("pipe1_latency_b", DWT'(resp_valid[1]), DWT'(1));
            chk("pipe1_data_3ff", resp_rdata[1], 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978);
            drain(1);
            for (int a = 0; a < 32; a++)
               do_req(1, 1'b1, AW'(a), {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF);
            fork
               for (int i = 0; i < 4; i++) do_req(1, 1'b0, AW'(i), '0, '0);
               begin
                  repeat (2) tick(1);
                  resp_ready[1] = 1'b0;
                  for (int c = 0; c < 3; c++) begin
                     #1;
                     chk("stall_valid1", DWT'(resp_valid[1]), DWT'(1));
                     chk("stall_ready1", DWT'(req_ready[1]), DWT'(0));
                     tick(1);
                  end
                  resp_ready[1] = 1'b1;
               end
            join
            drain(1);
         end
      join

      @(negedge clock);
      do_req(0, 1'b0, 10'h3FF, '0, '0);
      #1 chk("pipe0_latency", DWT'(resp_valid[0]), DWT'(1));
      chk("init_zero_3ff", resp_rdata[0], '0);
      drain(0);

      do_req(0, 1'b1, 10'h005, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 16'hFFFF);
      do_req(0, 1'b1, 10'h005, 128'h000000AA, 16'h0001);
      do_req(0, 1'b0, 10'h005, '0, '0);
      #1 chk("lane0_merge", resp_rdata[0], 128'h0F0E0D0C_0B0A0908_07060504_030201AA);
      drain(0);

      do_req(0, 1'b1, 10'h007, {16{8'h55}}, 16'hFFFF);
      do_req(0, 1'b0, 10'h007, '0, '0);
      #1 chk("raw_next_cycle", resp_rdata[0], {16{8'h55}});
      do_req(0, 1'b1, 10'h007, {16{8'hFF}}, 16'h0000);
      do_req(0, 1'b0, 10'h007, '0, '0);
      #1 chk("zero_mask_noop", resp_rdata[0], {16{8'h55}});
      drain(0);

      fork
         rnd_run(0, 300);
         rnd_run(1, 300);
      join

      resp_ready[0] = 1'b0;
      do_req(0, 1'b0, 10'h005, '0, '0);
      #3 reset_n = 1'b0;
      #1;
      chk("async_rst_valid", DWT'(resp_valid[0]), DWT'(0));
      chk("async_rst_rdata", resp_rdata[0], '0);
      chk("async_rst_ready", DWT'(req_ready[0]), DWT'(0));
      chk("async_rst_done", DWT'(init_done[0]), DWT'(0));
      exp_q0.delete();
      zero_model0();
      resp_ready[0] = 1'b1;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      repeat (300) @(negedge clock);
      #3 reset_n = 1'b0;
      #1;
      chk("midinit_rst_ready", DWT'(req_ready[0]), DWT'(0));
      chk("midinit_rst_done", DWT'(init_done[0]), DWT'(0));
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      wait_init0(n, early);
      chk("reinit_cycles0", DWT'(n), DWT'(1024));
      chk("reinit_early_ready0", DWT'(early), DWT'(0));
      @(negedge clock);
      do_req(0, 1'b0, 10'h005, '0, '0);
      do_req(1, 1'b0, 10'h003, '0, '0);
      drain(0);
      drain(1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
